// File: rtl/adc_spi_sampler.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_sampler
// Purpose  : Periodic SPI ADC trigger/capture; presents a signed 16-bit sample
//            with a one-cycle refresh strobe. Define
//            ADC_SPI_SAMPLER_OFFSET_BINARY_EN for offset-binary converters.
// Revision : 1.0 - initial release
// ============================================================================
module adc_spi_sampler #(
    parameter int CLK_DIV       = 2,
    parameter int CONV_CYCLES   = 4,
    parameter int SAMPLE_PERIOD = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    output logic        adc_convst,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    input  logic        adc_miso,
    output logic [15:0] sample,
    output logic        data_refresh,
    output logic        busy,
    output logic        overrun
);

    localparam int c_TIMER_W = $clog2(SAMPLE_PERIOD);
    localparam int c_CONV_W  = $clog2(CONV_CYCLES + 1);
    localparam int c_DIV_W   = $clog2(CLK_DIV + 1);

    localparam logic [c_TIMER_W-1:0] c_TIMER_LAST   = c_TIMER_W'(SAMPLE_PERIOD - 1);
    localparam logic [c_CONV_W-1:0]  c_CONV_LAST    = c_CONV_W'(CONV_CYCLES - 1);
    localparam logic [c_DIV_W-1:0]   c_DIV_LAST     = c_DIV_W'(CLK_DIV - 1);
    localparam logic [5:0]           c_HALF_PERIODS = 6'd32;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_CONVERT = 2'd1;
    localparam logic [1:0] c_SHIFT   = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    logic [1:0]           r_state;
    logic [c_TIMER_W-1:0] r_timer;
    logic [c_CONV_W-1:0]  r_conv_cnt;
    logic [c_DIV_W-1:0]   r_div_cnt;
    logic [5:0]           r_half_cnt;
    logic [15:0]          r_shift;
    logic [15:0]          r_sample;
    logic                 r_convst;
    logic                 r_cs_n;
    logic                 r_sclk;
    logic                 r_refresh;
    logic                 r_busy;
    logic                 r_overrun;

    logic                 w_tick;
    logic [15:0]          w_result;

    assign w_tick = enable && (r_timer == c_TIMER_LAST);

`ifdef ADC_SPI_SAMPLER_OFFSET_BINARY_EN
    assign w_result = {~r_shift[15], r_shift[14:0]};
`else
    assign w_result = r_shift;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
        end else if (!enable || w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_conv_cnt <= '0;
            r_div_cnt  <= '0;
            r_half_cnt <= '0;
            r_shift    <= '0;
            r_sample   <= '0;
            r_convst   <= 1'b0;
            r_cs_n     <= 1'b1;
            r_sclk     <= 1'b0;
            r_refresh  <= 1'b0;
            r_busy     <= 1'b0;
            r_overrun  <= 1'b0;
        end else begin
            r_refresh <= 1'b0;
            // A tick that finds the FSM occupied is dropped, not queued
            r_overrun <= w_tick && (r_state != c_IDLE);
            case (r_state)
                c_IDLE: begin
                    if (w_tick) begin
                        r_state    <= c_CONVERT;
                        r_convst   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_conv_cnt <= '0;
                    end
                end
                c_CONVERT: begin
                    if (r_conv_cnt == c_CONV_LAST) begin
                        r_state    <= c_SHIFT;
                        r_convst   <= 1'b0;
                        r_cs_n     <= 1'b0;
                        r_div_cnt  <= '0;
                        r_half_cnt <= '0;
                    end else begin
                        r_conv_cnt <= r_conv_cnt + 1'b1;
                    end
                end
                c_SHIFT: begin
                    // One extra cycle after the last falling edge before DONE
                    if (r_half_cnt == c_HALF_PERIODS) begin
                        r_state   <= c_DONE;
                        r_cs_n    <= 1'b1;
                        r_sample  <= w_result;
                        r_refresh <= 1'b1;
                    end else if (r_div_cnt == c_DIV_LAST) begin
                        r_div_cnt  <= '0;
                        r_sclk     <= ~r_sclk;
                        r_half_cnt <= r_half_cnt + 1'b1;
                        if (!r_sclk) begin
                            r_shift <= {r_shift[14:0], adc_miso};
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign adc_convst   = r_convst;
    assign adc_cs_n     = r_cs_n;
    assign adc_sclk     = r_sclk;
    assign sample       = r_sample;
    assign data_refresh = r_refresh;
    assign busy         = r_busy;
    assign overrun      = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_spi_sampler
// Purpose  : Scoreboard bench for adc_spi_sampler; instance 0 uses the default
//            period, instance 1 a 50-cycle period that forces overruns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_spi_sampler;

    localparam int CD  = 2;
    localparam int CC  = 4;
    localparam int LAT = CC + 32 * CD + 2;
    localparam int N   = 2;
    localparam int SP0 = 200;
    localparam int SP1 = 50;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic [N-1:0] miso;
    wire  [N-1:0] convst, cs_n, sclk, refresh, busy, ovr;
    wire  [N-1:0][15:0] smp;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [15:0] q0[$];
    logic [15:0] q1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_spi_sampler #(.CLK_DIV(CD), .CONV_CYCLES(CC), .SAMPLE_PERIOD(SP0)) u_dut0 (
        .clk(clk), .rst(rst), .enable(enable),
        .adc_convst(convst[0]), .adc_cs_n(cs_n[0]), .adc_sclk(sclk[0]),
        .adc_miso(miso[0]), .sample(smp[0]), .data_refresh(refresh[0]),
        .busy(busy[0]), .overrun(ovr[0])
    );

    adc_spi_sampler #(.CLK_DIV(CD), .CONV_CYCLES(CC), .SAMPLE_PERIOD(SP1)) u_dut1 (
        .clk(clk), .rst(rst), .enable(enable),
        .adc_convst(convst[1]), .adc_cs_n(cs_n[1]), .adc_sclk(sclk[1]),
        .adc_miso(miso[1]), .sample(smp[1]), .data_refresh(refresh[1]),
        .busy(busy[1]), .overrun(ovr[1])
    );

    function automatic logic [15:0] b16(input logic v);
        return {15'd0, v};
    endfunction

    task automatic check(input string name, input int inst, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] cycle %0d: got %0h expected %0h", name, inst, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] adc_word(input int frame);
        case (frame)
            0:       return 16'hA5C3;
            1:       return 16'h8000;
            2:       return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [15:0] expected_sample(input logic [15:0] raw);
`ifdef ADC_SPI_SAMPLER_OFFSET_BINARY_EN
        return raw ^ 16'h8000;
`else
        return raw;
`endif
    endfunction

    // ADC model: new word per chip-select fall, next bit after each SCLK rise
    logic [15:0] word  [N];
    int          nrise [N];
    int          frame [N];
    logic [N-1:0] pcs   = '1;
    logic [N-1:0] psclk = '0;

    initial begin
        for (int i = 0; i < N; i++) begin
            word[i] = '0; nrise[i] = 16; frame[i] = 0;
        end
        miso = '0;
    end

    always @(negedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (pcs[i] && !cs_n[i]) begin
                word[i]  = adc_word(frame[i]);
                frame[i] = frame[i] + 1;
                nrise[i] = 0;
                if (!rst) begin
                    if (i == 0) q0.push_back(expected_sample(word[i]));
                    else        q1.push_back(expected_sample(word[i]));
                end
            end else if (!cs_n[i] && sclk[i] && !psclk[i]) begin
                nrise[i] = nrise[i] + 1;
            end
            if (!cs_n[i] && nrise[i] < 16) miso[i] = word[i][15 - nrise[i]];
            else                            miso[i] = 1'($urandom_range(0, 1));
            pcs[i]   = cs_n[i];
            psclk[i] = sclk[i];
        end
    end

    // Reference timeline: conv start, refresh and overrun cycles per instance
    int          m_t     [N];
    int          m_conv  [N];
    int          m_ref   [N];
    int          m_ovr   [N];
    int          m_rises [N];
    logic [15:0] m_sample[N];
    logic [N-1:0] mprev_sclk = '0;

    initial begin
        for (int i = 0; i < N; i++) begin
            m_t[i] = 0; m_conv[i] = -1000; m_ref[i] = -1000; m_ovr[i] = -1000;
            m_rises[i] = 0; m_sample[i] = '0;
        end
    end

    always @(negedge clk) begin
        int   k, d, sp;
        logic tick;
        logic [15:0] e;
        k = cyc;
        for (int i = 0; i < N; i++) begin
            sp = (i == 0) ? SP0 : SP1;
            if (k > 0) begin
                d = k - (m_conv[i] + CC);
                check("adc_convst", i, b16(convst[i]), b16(k >= m_conv[i] && k < m_conv[i] + CC));
                check("busy", i, b16(busy[i]), b16(k >= m_conv[i] && k <= m_ref[i]));
                check("adc_cs_n", i, b16(cs_n[i]), b16(!(d >= 0 && k < m_ref[i])));
                check("adc_sclk", i, b16(sclk[i]), b16(d >= 0 && d < 32 * CD && ((d / CD) % 2) == 1));
                check("data_refresh", i, b16(refresh[i]), b16(k == m_ref[i]));
                check("overrun", i, b16(ovr[i]), b16(k == m_ovr[i]));
                if (k == m_conv[i]) m_rises[i] = 0;
                if (sclk[i] && !mprev_sclk[i]) m_rises[i] = m_rises[i] + 1;
                if (k == m_ref[i]) begin
                    check("sclk_rises", i, 16'(m_rises[i]), 16'd16);
                    checks++;
                    if ((i == 0 ? q0.size() : q1.size()) == 0) begin
                        errors++;
                        $display("FAIL scoreboard[%0d] cycle %0d: got refresh expected queued word", i, k);
                    end else begin
                        e = (i == 0) ? q0.pop_front() : q1.pop_front();
                        m_sample[i] = e;
                    end
                end
                check("sample", i, smp[i], m_sample[i]);
            end
            mprev_sclk[i] = sclk[i];
            if (rst) begin
                m_t[i] = 0; m_conv[i] = -1000; m_ref[i] = -1000; m_ovr[i] = -1000;
                m_sample[i] = '0;
                if (i == 0) q0.delete();
                else        q1.delete();
            end else begin
                tick = enable && (m_t[i] == sp - 1);
                if (tick) begin
                    if (k >= m_conv[i] && k <= m_ref[i]) begin
                        m_ovr[i] = k + 1;
                    end else begin
                        m_conv[i] = k + 1;
                        m_ref[i]  = k + LAT;
                    end
                end
                m_t[i] = (!enable || tick) ? 0 : m_t[i] + 1;
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bounded wait for instance 0 to enter SHIFT and produce a number of SCLK rises
    task automatic wait_shift(input int rises);
        int   guard;
        int   seen;
        logic p;
        guard = 0; seen = 0; p = 1'b0;
        while (cs_n[0] !== 1'b0 && guard < 500) begin
            cycles(1); guard++;
        end
        while (seen < rises && guard < 500) begin
            cycles(1); guard++;
            if (sclk[0] && !p) seen++;
            p = sclk[0];
        end
        checks++;
        if (guard >= 500) begin
            errors++;
            $display("FAIL wait_shift: got %0d rises expected %0d within 500 cycles", seen, rises);
        end
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        cycles(3);
        rst = 1'b0;
        cycles(700);

        wait_shift(0);
        cycles($urandom_range(5, 40));
        enable = 1'b0;
        cycles(400);
        enable = 1'b1;
        cycles(500);

        wait_shift(5);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        cycles(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
